tick_gen_multi: RTL and testbench
=================================

# tick_gen_multi

Multi-channel programmable tick generator. It replaces the fixed-divisor 10 Hz tick source in the UART/counter subsystem. Each of N_CH independent channels divides clk by a runtime-programmable divisor and emits single-cycle tick pulses in either periodic or one-shot mode. Per-channel enable/clear gating is provided, and divisor updates are shadowed so they never produce a truncated period.

## Interface
- N_CH, 4, number of independent channels (1..16)
- DIV_W, 32, divisor/counter width in bits
- DEFAULT_DIV, 10_000_000, divisor loaded into every channel at reset (10 Hz at 100 MHz)
- CH_W, $clog2(N_CH) (min 1), channel-select width (localparam)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  N_CH  per-channel count enable, level
- clear  in  N_CH  per-channel synchronous clear, level, priority over enable
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  CH_W  channel addressed by cfg_we
- cfg_div  in  DIV_W  new divisor
- cfg_oneshot  in  1  new mode: 0 = periodic, 1 = one-shot
- tick  out  N_CH  per-channel tick, one-cycle pulse, registered
- done  out  N_CH  one-shot channel has fired and is parked
- cur_count  out  N_CH*DIV_W  per-channel counter values, concatenated, channel 0 in LSBs

## Operation
- Per channel: active divisor `div_act`, shadow divisor `div_shd`, mode `os_act`/`os_shd`, counter `cnt`, `pending` flag.
- Reset: cnt=0, tick=0, done=0, div_act=div_shd=DEFAULT_DIV, mode periodic, pending=0.
- Divisor 0 is treated as 1. Divisor 1 produces a tick on every enabled cycle.
- Config write: if cfg_we=1, the channel cfg_ch gets div_shd<=cfg_div, os_shd<=cfg_oneshot, pending<=1. cfg_ch >= N_CH is ignored.
- Shadow transfer (div_act<=div_shd, mode<=os_shd, pending<=0) happens only when pending=1 and one of these holds:
  - a wrap occurs;
  - clear is high;
  - the channel is idle (enable=0 and cnt=0).
- A write coinciding with a transfer cycle: the new write wins and remains pending for the next transfer.
- Per-edge priority, per channel:
  1. clear: cnt<=0, tick<=0, done<=0.
  2. done=1: hold. tick<=0, cnt stays 0.
  3. enable=0: cnt holds, tick<=0.
  4. enable=1 and cnt==div_act-1 (wrap): cnt<=0, tick<=1. If the active mode is one-shot, done<=1.
  5. enable=1 otherwise: cnt<=cnt+1, tick<=0.
- Wrap comparison uses the div_act value in force before any same-edge transfer.
- Channels are fully independent. There is no cross-channel arbitration.

## Timing
- tick is high for exactly one clk cycle per period.
- With enable held high from cnt=0, the first tick appears after the div_act-th rising edge. Subsequent ticks follow every div_act cycles.
- Enable dropping mid-period freezes the phase. Re-enabling resumes the count, so total enabled cycles between ticks equals div_act.
- clear asserted in the same cycle as a wrap: the tick is suppressed and cnt=0.
- Async rst mid-period: all outputs drop immediately, and registers restart from reset values.
- done rises on the same edge as the final one-shot tick and stays high until clear or rst.
- A divisor shrunk below the current cnt during a transfer cannot occur, because transfer happens only at cnt=0 states.

## Structure
- Package tick_gen_pkg holds:
  - the mode typedef (MODE_PERIODIC, MODE_ONESHOT);
  - the DEFAULT_DIV constant;
  - a function that normalises divisor 0 to 1.
- Sub-module tick_channel contains one channel's counter, shadow registers, pending logic and outputs.
- The top-level module instantiates N_CH copies with a generate loop and decodes cfg_we/cfg_ch into per-channel write strobes.

## Test plan
- Reset, then all channels enabled with DEFAULT_DIV scaled down to 10 for simulation: ticks appear at cycles 10, 20, 30 after enable, each exactly 1 cycle wide. done=0.
- Channel 1 with div=5, enable toggled low for 3 cycles after cnt=2: next tick arrives 8 cycles after enable first rose (5 enabled cycles + 3 held). cnt holds at 2 while low.
- Channel 2 mid-period at cnt=3 of div=10, write div=4: the current period still completes at 10, then ticks follow every 4 cycles. pending clears at the wrap.
- Channel 3 in one-shot mode with div=6: a single tick at cycle 6 and done=1, no further ticks over 50 cycles. clear then re-enable gives a new tick after 6 more cycles.
- clear and wrap in the same cycle on channel 0: no tick, cnt=0. Writes of div=0 and div=1 both give a tick on every enabled cycle. A write with cfg_ch=N_CH has no effect.
- rst asserted asynchronously mid-period on all channels: tick, done and cnt go to 0 immediately. After release, the divisor is back to DEFAULT_DIV.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared mode type, reset divisor and divisor normalisation
package tick_gen_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_t;

    localparam int unsigned DEFAULT_DIV = 10_000_000;

    // A zero divisor would never wrap; it behaves as divide-by-one instead.
    function automatic logic [63:0] norm_div(input logic [63:0] d);
        return (d == 64'd0) ? 64'd1 : d;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one divider channel with shadowed divisor/mode and one-shot parking
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int               DIV_W   = 32,
    parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(tick_gen_pkg::DEFAULT_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    output logic             tick,
    output logic             done,
    output logic [DIV_W-1:0] cnt
);

    mode_t            os_act, os_shd;
    logic [DIV_W-1:0] div_act, div_shd, div_eff;
    logic             pending, wrap, xfer;

    // Shadow moves to active only at cnt=0 states, so a period is never truncated.
    always_comb begin
        div_eff = DIV_W'(norm_div(64'(div_act)));
        wrap    = enable && !done && (cnt == div_eff - DIV_W'(1));
        xfer    = pending && (wrap || clear || (!enable && cnt == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
            done <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
            done <= 1'b0;
        end else if (done || !enable) begin
            tick <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
            done <= (os_act == MODE_ONESHOT);
        end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
        end
    end

    // A write landing on a transfer edge stays pending for the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_act <= RST_DIV;
            div_shd <= RST_DIV;
            os_act  <= MODE_PERIODIC;
            os_shd  <= MODE_PERIODIC;
            pending <= 1'b0;
        end else begin
            div_act <= xfer ? div_shd : div_act;
            os_act  <= xfer ? os_shd : os_act;
            div_shd <= cfg_we ? cfg_div : div_shd;
            os_shd  <= cfg_we ? mode_t'(cfg_oneshot) : os_shd;
            pending <= cfg_we || (pending && !xfer);
        end
    end

endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: N_CH independent programmable tick dividers with shared config port
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int               N_CH        = 4,
    parameter int               DIV_W       = 32,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(tick_gen_pkg::DEFAULT_DIV),
    localparam int              CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       enable,
    input  logic [N_CH-1:0]       clear,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic                  cfg_oneshot,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       done,
    output logic [N_CH*DIV_W-1:0] cur_count
);

    logic [N_CH-1:0] ch_we;

    // Out-of-range cfg_ch matches no channel and is silently dropped.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ch_we[c] = cfg_we && (cfg_ch == CH_W'(c));
        tick_channel #(
            .DIV_W   (DIV_W),
            .RST_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable[c]),
            .clear       (clear[c]),
            .cfg_we      (ch_we[c]),
            .cfg_div     (cfg_div),
            .cfg_oneshot (cfg_oneshot),
            .tick        (tick[c]),
            .done        (done[c]),
            .cnt         (cur_count[c*DIV_W +: DIV_W])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed vector table plus hand-written multi-cycle sequences
module tb_tick_gen_multi;

    localparam int N_CH  = 5;
    localparam int DIV_W = 32;
    localparam int CH_W  = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_CH-1:0]       enable = '0;
    logic [N_CH-1:0]       clear = '0;
    logic                  cfg_we = 1'b0;
    logic [CH_W-1:0]       cfg_ch = '0;
    logic [DIV_W-1:0]      cfg_div = '0;
    logic                  cfg_oneshot = 1'b0;
    logic [N_CH-1:0]       tick, done;
    logic [N_CH*DIV_W-1:0] cur_count;
    logic [N_CH-1:0]       all_ch = '1;
    int                    n_tests = 0;
    int                    n_fail = 0;

    typedef struct {
        int          ch;
        logic        en;
        logic        clr;
        logic        we;
        logic [CH_W-1:0]  wch;
        logic [DIV_W-1:0] div;
        logic        exp_tick;
        logic [DIV_W-1:0] exp_cnt;
    } vec_t;

    vec_t v[$];

    tick_gen_multi #(
        .N_CH        (N_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .tick        (tick),
        .done        (done),
        .cur_count   (cur_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [DIV_W-1:0] cnt_of(input int ch);
        return cur_count[ch*DIV_W +: DIV_W];
    endfunction

    function automatic vec_t mk(input int ch, input logic en, input logic clr, input logic we,
                                input int wch, input int div, input logic et, input int ec);
        vec_t r;
        r.ch = ch; r.en = en; r.clr = clr; r.we = we;
        r.wch = CH_W'(wch); r.div = DIV_W'(div); r.exp_tick = et; r.exp_cnt = DIV_W'(ec);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int d, input logic os);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(d); cfg_oneshot = os;
        cyc();
        cfg_we = 1'b0;
        cyc();
    endtask

    initial begin
        // vector table: clear-vs-wrap on ch0, div 0/1 on ch4, out-of-range cfg_ch
        v.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2));
        v.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(4, 0, 0, 1, 4, 0, 0, 0));
        v.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(4, 1, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(4, 1, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(4, 0, 0, 1, 4, 1, 0, 0));
        v.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(4, 1, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(4, 1, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(1, 0, 0, 1, 5, 2, 0, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        v.push_back(mk(1, 1, 0, 0, 0, 0, 0, 2));
        v.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3));
        v.push_back(mk(1, 1, 0, 0, 0, 0, 0, 4));
        v.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));

        cyc();
        cyc();
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", |cur_count, 0);
        rst = 1'b0;

        // all channels at default divisor 10
        enable = '1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            chk($sformatf("dflt_tick_%0d", i), tick, (i % 10 == 0) ? all_ch : '0);
        end
        chk("dflt_done", done, 0);
        chk("dflt_cnt0", cnt_of(0), 0);
        enable = '0;

        // ch1 div 5 with a 3-cycle enable gap at cnt=2
        wr(1, 5, 1'b0);
        enable[1] = 1'b1;
        cyc();
        cyc();
        chk("gap_cnt_before", cnt_of(1), 2);
        enable[1] = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            cyc();
            chk($sformatf("gap_hold_cnt_%0d", i), cnt_of(1), 2);
            chk($sformatf("gap_hold_tick_%0d", i), tick[1], 0);
        end
        enable[1] = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            cyc();
            chk($sformatf("gap_tick_%0d", i), tick[1], i == 8);
        end
        chk("gap_cnt_after", cnt_of(1), 0);
        enable[1] = 1'b0;

        // ch2 mid-period rewrite to div 4: old period completes, then every 4
        enable[2] = 1'b1;
        cfg_ch = 3'd2; cfg_div = 4; cfg_oneshot = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            cfg_we = (i == 4);
            cyc();
            chk($sformatf("shadow_tick_%0d", i), tick[2], i == 10 || i == 14 || i == 18);
        end
        cfg_we = 1'b0;
        enable[2] = 1'b0;
        chk("shadow_cnt_end", cnt_of(2), 0);

        // ch3 one-shot div 6, parked, then cleared and re-armed
        wr(3, 6, 1'b1);
        enable[3] = 1'b1;
        for (int i = 1; i <= 56; i++) begin
            cyc();
            chk($sformatf("os_tick_%0d", i), tick[3], i == 6);
            chk($sformatf("os_done_%0d", i), done[3], i >= 6);
        end
        clear[3] = 1'b1;
        cyc();
        chk("os_clr_done", done[3], 0);
        chk("os_clr_cnt", cnt_of(3), 0);
        clear[3] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk($sformatf("os_rearm_tick_%0d", i), tick[3], i == 6);
        end
        chk("os_rearm_done", done[3], 1);
        enable[3] = 1'b0;
        clear[3] = 1'b1;
        cyc();
        clear[3] = 1'b0;

        foreach (v[k]) begin
            enable = '0;
            clear = '0;
            enable[v[k].ch] = v[k].en;
            clear[v[k].ch] = v[k].clr;
            cfg_we = v[k].we; cfg_ch = v[k].wch; cfg_div = v[k].div; cfg_oneshot = 1'b0;
            cyc();
            chk($sformatf("vec%0d_tick", k), tick[v[k].ch], v[k].exp_tick);
            chk($sformatf("vec%0d_cnt", k), cnt_of(v[k].ch), v[k].exp_cnt);
        end
        cfg_we = 1'b0;
        enable = '0;

        // async reset mid-period with ch3 parked and ch4 ticking
        enable = '1;
        for (int i = 1; i <= 7; i++) cyc();
        chk("pre_rst_tick", tick, 5'b10000);
        chk("pre_rst_done", done, 5'b01000);
        chk("pre_rst_cnt0", cnt_of(0), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tick", tick, 0);
        chk("arst_done", done, 0);
        chk("arst_cnt", |cur_count, 0);
        cyc();
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk($sformatf("post_rst_tick_%0d", i), tick, (i % 10 == 0) ? all_ch : '0);
        end
        chk("post_rst_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
